// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: streams one coefficient frame into a shadow bank and
// commits it atomically to the active bank that feeds the FIR core.
module fir_coeff_loader #(
    parameter int              NTAPS    = 33,
    parameter int              CW       = 16,
    parameter logic [CW-1:0]   RST_TAP0 = 16'h7FFF,
    parameter int              TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CW-1:0]         s_data,
    input  logic                  s_last,
    output logic [NTAPS*CW-1:0]   coeff_flat,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code,
    output logic [7:0]            load_cnt
);

    localparam int IW = $clog2(NTAPS + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_LONG    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [NTAPS*CW-1:0] RST_FLAT = (NTAPS*CW)'(RST_TAP0);
    localparam logic [IW-1:0]       LAST_IDX = IW'(NTAPS - 1);
    localparam logic [TW-1:0]       IDLE_MAX = TW'(TIMEOUT - 1);

    logic [1:0]          state_r, state_s;
    logic [IW-1:0]       idx_r, idx_s;
    logic [TW-1:0]       idle_r, idle_s;
    logic [1:0]          err_code_r, err_code_s;
    logic [7:0]          load_cnt_r, load_cnt_s;
    logic                load_done_s, load_err_s, commit_s;
    logic                s_ready_r, busy_r, load_done_r, load_err_r;
    logic [NTAPS*CW-1:0] coeff_r;
    logic [CW-1:0]       shadow_r [NTAPS];
    logic                beat_s;
    logic [IW-1:0]       wr_idx_s;

    assign beat_s   = s_valid && s_ready_r;
    assign wr_idx_s = (state_r == ST_IDLE) ? '0 : idx_r;

    // Next-state, error and commit decisions for the frame FSM
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        idle_s      = idle_r;
        err_code_s  = err_code_r;
        load_cnt_s  = load_cnt_r;
        load_done_s = 1'b0;
        load_err_s  = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idle_s = '0;
                if (beat_s) begin
                    idx_s      = IW'(1);
                    err_code_s = ERR_NONE;
                    if (s_last && (NTAPS > 1)) begin
                        idx_s      = '0;
                        err_code_s = ERR_SHORT;
                        load_err_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    idx_s = '0;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    idle_s = '0;
                    idx_s  = idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        state_s = s_last ? ST_COMMIT : ST_DRAIN;
                    end else if (s_last) begin
                        state_s    = ST_IDLE;
                        idx_s      = '0;
                        err_code_s = ERR_SHORT;
                        load_err_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else if (idle_r == IDLE_MAX) begin
                    state_s    = ST_IDLE;
                    idx_s      = '0;
                    idle_s     = '0;
                    err_code_s = ERR_TIMEOUT;
                    load_err_s = 1'b1;
                end else begin
                    idle_s = idle_r + TW'(1);
                end
            end
            ST_DRAIN: begin
                // Surplus beats are swallowed until the host closes the frame
                if (beat_s) begin
                    idle_s = '0;
                    if (s_last) begin
                        state_s    = ST_IDLE;
                        idx_s      = '0;
                        err_code_s = ERR_LONG;
                        load_err_s = 1'b1;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (idle_r == IDLE_MAX) begin
                    state_s    = ST_IDLE;
                    idx_s      = '0;
                    idle_s     = '0;
                    err_code_s = ERR_TIMEOUT;
                    load_err_s = 1'b1;
                end else begin
                    idle_s = idle_r + TW'(1);
                end
            end
            ST_COMMIT: begin
                state_s     = ST_IDLE;
                idx_s       = '0;
                idle_s      = '0;
                commit_s    = 1'b1;
                load_done_s = 1'b1;
                load_cnt_s  = load_cnt_r + 8'd1;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
                idle_s  = '0;
            end
        endcase
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            idle_r      <= '0;
            err_code_r  <= ERR_NONE;
            load_cnt_r  <= 8'd0;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
            s_ready_r   <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            idle_r      <= idle_s;
            err_code_r  <= err_code_s;
            load_cnt_r  <= load_cnt_s;
            load_done_r <= load_done_s;
            load_err_r  <= load_err_s;
            s_ready_r   <= (state_s != ST_COMMIT);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Shadow bank fill; beats beyond the last tap never reach it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_r[k] <= '0;
            end
        end else if (beat_s && ((state_r == ST_IDLE) || (state_r == ST_LOAD))) begin
            shadow_r[wr_idx_s] <= s_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active bank only ever changes as a whole, on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_r <= RST_FLAT;
        end else if (commit_s) begin
            for (int k = 0; k < NTAPS; k++) begin
                coeff_r[k*CW +: CW] <= shadow_r[k];
            end
        end else begin
            coeff_r <= coeff_r;
        end
    end

    assign s_ready    = s_ready_r;
    assign busy       = busy_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;
    assign err_code   = err_code_r;
    assign load_cnt   = load_cnt_r;
    assign coeff_flat = coeff_r;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized scoreboard bench for fir_coeff_loader: a frame-level model predicts
// each commit or rejection and a monitor checks every load_done/load_err pulse.
module tb_fir_coeff_loader;

    localparam int NTAPS   = 33;
    localparam int CW      = 16;
    localparam int TIMEOUT = 1024;
    localparam int FW      = NTAPS * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [FW-1:0] coeff_flat;
    logic          busy, load_done, load_err;
    logic [1:0]    err_code;
    logic [7:0]    load_cnt;

    fir_coeff_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .coeff_flat(coeff_flat),
        .busy(busy), .load_done(load_done), .load_err(load_err),
        .err_code(err_code), .load_cnt(load_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        logic [1:0]    code;
        int            at;
        logic [7:0]    cnt;
        logic [FW-1:0] bank;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] frame_q[$];
    logic [FW-1:0] model_bank;
    int            model_cnt;
    int            big_gap_at = -1;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          prev_ready = 1'b1;
    logic [FW-1:0] rst_bank;

    task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Monitor: every status pulse must match the oldest predicted event
    always @(negedge clk) begin
        if (!rst) begin
            if (load_done || load_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {load_done, load_err}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {load_done, load_err}, e.is_err ? 2'b01 : 2'b10);
                    chk("pulse_cycle", cyc, e.at);
                    chk("coeff_flat", coeff_flat, e.bank);
                    chk("load_cnt", load_cnt, e.cnt);
                    chk("busy_after", busy, 1'b0);
                    if (e.is_err) chk("err_code", err_code, e.code);
                    else          chk("ready_gap", {prev_ready, s_ready}, 2'b01);
                end
            end
            prev_ready = s_ready;
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_beat(input logic [CW-1:0] d, input logic last, output int acc);
        logic r;
        int   tries;
        tries   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) break;
            tries++;
            if (tries > 8) begin
                chk("ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        acc     = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = CW'($urandom);
    endtask

    // Plays frame_q and predicts its outcome from the frame length alone
    task automatic play(input bit with_last, input int gapmax);
        int   e;
        int   len;
        exp_t x;
        e   = 0;
        len = frame_q.size();
        for (int i = 0; i < len; i++) begin
            if (i > 0 && i == big_gap_at) idle(TIMEOUT - 1);
            else if (i > 0 && gapmax > 0) idle($urandom_range(0, gapmax));
            put_beat(frame_q[i], with_last && (i == len - 1), e);
        end
        x.is_err = 1'b1;
        x.bank   = model_bank;
        x.cnt    = 8'(model_cnt);
        x.at     = e;
        if (!with_last) begin
            x.code = 2'd3;
            x.at   = e + TIMEOUT;
        end else if (len < NTAPS) begin
            x.code = 2'd1;
        end else if (len > NTAPS) begin
            x.code = 2'd2;
        end else begin
            for (int k = 0; k < NTAPS; k++) model_bank[k*CW +: CW] = frame_q[k];
            model_cnt = (model_cnt + 1) % 256;
            x.is_err  = 1'b0;
            x.code    = 2'd0;
            x.at      = e + 1;
            x.bank    = model_bank;
            x.cnt     = 8'(model_cnt);
        end
        sb.push_back(x);
        if (!with_last) idle(TIMEOUT + 3);
    endtask

    task automatic make_frame(input int len, input int mode);
        frame_q.delete();
        for (int k = 0; k < len; k++) begin
            if (mode == 0)      frame_q.push_back(CW'(k + 1));
            else if (mode == 1) frame_q.push_back(16'h8000 + CW'(k * 3));
            else                frame_q.push_back(CW'($urandom));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_coeff"}, coeff_flat, rst_bank);
        chk({tag, "_err_code"}, err_code, 2'd0);
        chk({tag, "_load_cnt"}, load_cnt, 8'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_pulses"}, {load_done, load_err}, 2'b00);
    endtask

    initial begin
        int dummy;
        rst_bank   = '0;
        rst_bank[CW-1:0] = 16'h7FFF;
        model_bank = rst_bank;
        model_cnt  = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        idle(2);

        // Exact-length frame with an incrementing pattern
        make_frame(NTAPS, 0); play(1'b1, 0); idle(3);
        // Short and long frames must leave the active bank alone
        make_frame(20, 2); play(1'b1, 0); idle(4);
        chk("err_code_held", err_code, 2'd1);
        make_frame(40, 2); play(1'b1, 0); idle(3);
        // Timeouts in LOAD and in DRAIN, each followed by a good frame
        make_frame(10, 2); play(1'b0, 0);
        make_frame(NTAPS, 2); play(1'b1, 2); idle(2);
        make_frame(36, 2); play(1'b0, 0);
        make_frame(NTAPS, 2); play(1'b1, 0);
        // Sign-bit data with random gaps, including one just under the timeout
        big_gap_at = 7;
        make_frame(NTAPS, 1); play(1'b1, 6);
        big_gap_at = -1;
        // Random mix of lengths, frames back to back
        for (int f = 0; f < 24; f++) begin
            make_frame(($urandom_range(0, 1) == 0) ? NTAPS : $urandom_range(1, 45), 2);
            play(1'b1, $urandom_range(0, 3));
        end
        idle(4);

        // Reset in the middle of a frame
        frame_q.delete();
        for (int k = 0; k < 20; k++) put_beat(CW'($urandom), 1'b0, dummy);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrst");
        chk("sb_empty_at_rst", sb.size(), 0);
        sb.delete();
        model_bank = rst_bank;
        model_cnt  = 0;
        rst = 1'b0;
        idle(3);
        check_reset_values("post_rst");

        // 256 commits wrap the counter back to zero
        for (int f = 0; f < 256; f++) begin
            make_frame(NTAPS, 2);
            play(1'b1, 0);
        end
        idle(4);
        chk("load_cnt_wrap", load_cnt, 8'd0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
